vivo_frame_packer: RTL and testbench
====================================

// Module: vivo_frame_packer
// PURPOSE
//  Sits directly downstream of the VIVO FIFO pop port. Pulls variable-size element groups from it,
//  packs them into fixed BEAT_ELEMS-wide beats, and cuts the stream into frames of cfg_frame_len
//  elements. The last beat of each frame is flagged and may be partial. Output is valid/ready.
// PARAMETERS
//  ELEM_WIDTH       8    bits per element
//  FIFO_ELEMS_MAX   4    max elements per FIFO pop; equals the FIFO's OUT_ELEMS_MAX
//  BEAT_ELEMS       8    elements per output beat; elaboration error if < FIFO_ELEMS_MAX
//  MAX_FRAME_ELEMS  256  largest frame; LENW = $clog2(MAX_FRAME_ELEMS+1)
// PORTS
//  clk             in   1                          clock
//  rst_n           in   1                          async reset, active-low
//  cfg_frame_len   in   LENW                       frame length; sampled at frame start
//  fifo_valid      in   1                          FIFO pop data valid
//  fifo_ready      out  1                          pop accept
//  fifo_data       in   FIFO_ELEMS_MAX*ELEM_WIDTH  popped elements; element 0 in the low slice
//  fifo_num_elems  in   $clog2(FIFO_ELEMS_MAX+1)   count valid in fifo_data
//  fifo_req_elems  out  $clog2(FIFO_ELEMS_MAX+1)   elements requested from FIFO
//  m_valid         out  1                          beat valid
//  m_ready         in   1                          beat accept
//  m_data          out  BEAT_ELEMS*ELEM_WIDTH      beat; element 0 in the low slice; unused slots 0
//  m_num_elems     out  $clog2(BEAT_ELEMS+1)       valid elements in beat
//  m_last          out  1                          final beat of frame
//  err             out  1                          sticky protocol error
//  stat_frames     out  32                         completed frames (see CONFIGURATION)
//  stat_stall      out  32                         output stall cycles (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; fill=0; rem=0; staging cleared.
//  - FSM IDLE->FILL->EMIT->(FILL|IDLE).
//  - IDLE: if cfg_frame_len!=0, latch rem=min(cfg_frame_len,MAX_FRAME_ELEMS) and go to FILL.
//    If cfg_frame_len==0, stay in IDLE with req=0.
//  - FILL: fifo_req_elems = req_q, registered. req_q's next value is min(FIFO_ELEMS_MAX, rem,
//    BEAT_ELEMS-fill), computed from next-state fill and rem; it is 0 outside FILL.
//  - Because of this, req_q changes only on a pop or a state change. It MUST stay stable while
//    fifo_valid is pending, since the FIFO commits req at pop time.
//  - fifo_ready = (state==FILL) && (req_q!=0). A pop happens on fifo_valid && fifo_ready.
//  - On a pop: write req_q elements into staging slots fill..fill+req_q-1; then fill+=req_q and
//    rem-=req_q.
//  - If fifo_num_elems != req_q on a pop, set err=1 (cleared only by reset). Data is still taken
//    per req_q.
//  - FILL->EMIT when next fill==BEAT_ELEMS or next rem==0. A pop and the transition share the
//    same edge.
//  - EMIT: registered m_valid=1, m_num_elems=fill, m_last=(rem==0). m_data is stable until m_ready.
//  - No pops happen during EMIT. Throughput is deliberately not overlapped.
//  - Beat accept (m_valid && m_ready): clear fill and staging. If m_last, go to IDLE; the next
//    frame can latch one cycle later. Otherwise go to FILL.
//  - Latency: first FIFO request is issued 2 cycles after IDLE sees a nonzero length. A beat
//    appears 1 cycle after the completing pop.
//  - Arithmetic: rem is LENW bits and fill is $clog2(BEAT_ELEMS+1) bits. By construction
//    neither underflows nor overflows.
//  - Reset mid-frame: staging and partial frame are discarded, with no flush. The upstream FIFO
//    shares rst_n.
// CONFIGURATION
//  Macro VIVO_FRAME_PACKER_STATS_EN:
//  - Defined: stat_frames increments on each accepted beat with m_last. stat_stall increments
//    on each cycle with m_valid && !m_ready. Both saturate at 2^32-1 and reset to 0.
//  - Undefined: both ports are tied to 0 and no counter flops are built.
// STRUCTURE
//  Package vivo_pkg holds:
//  - typedef enum logic[1:0] {IDLE,FILL,EMIT} packer_state_e
//  - width helper localparams
//  - function vivo_min3()
//  Sub-module vivo_beat_stager: BEAT_ELEMS staging registers with an element-granular write
//  at an offset (wr_en, wr_offset, wr_count, wr_data) and a synchronous clear.
// TESTING
//  1. frame_len=8, FIFO holds 0x00..0x07 -> requests 4,4; one beat with elems 00..07,
//     m_num_elems=8, m_last=1.
//  2. frame_len=11 -> requests 4,4,3.
//     Beat0: 00..07, last=0. Beat1: 08..0A, num=3, last=1, slots 3..7 zero.
//  3. m_ready held low 10 cycles on a beat -> m_data stable, fifo_req_elems=0, no pops.
//     With STATS_EN, stat_stall=10.
//  4. FIFO holds 2 elements, frame_len=6 -> fifo_req_elems=4 held stable, no pop.
//     Push 2 more -> pop of 4, then req=2.
//  5. rst_n pulsed low after the first pop -> all outputs 0 immediately.
//     The next frame starts with fill=0 and err=0.
//  6. Force fifo_num_elems=3 while req=4 -> err=1 and stays 1. cfg_frame_len=0 -> stays in
//     IDLE with req=0.

Source files
------------

// File: rtl/vivo_pkg.sv
// Shared types, default sizing and helpers for the VIVO frame packer.
package vivo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT
    } packer_state_e;

    localparam int unsigned VIVO_ELEM_WIDTH      = 8;
    localparam int unsigned VIVO_FIFO_ELEMS_MAX  = 4;
    localparam int unsigned VIVO_BEAT_ELEMS      = 8;
    localparam int unsigned VIVO_MAX_FRAME_ELEMS = 256;

    localparam int unsigned VIVO_LENW = $clog2(VIVO_MAX_FRAME_ELEMS + 1);
    localparam int unsigned VIVO_FW   = $clog2(VIVO_BEAT_ELEMS + 1);
    localparam int unsigned VIVO_RW   = $clog2(VIVO_FIFO_ELEMS_MAX + 1);

    function automatic int unsigned vivo_min3(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/vivo_beat_stager.sv
// Beat staging registers: element-granular write of up to IN_ELEMS elements at an offset,
// synchronous clear.
module vivo_beat_stager
    import vivo_pkg::*;
#(
    parameter int unsigned ELEM_WIDTH = VIVO_ELEM_WIDTH,
    parameter int unsigned BEAT_ELEMS = VIVO_BEAT_ELEMS,
    parameter int unsigned IN_ELEMS   = VIVO_FIFO_ELEMS_MAX,
    localparam int unsigned OFFW = $clog2(BEAT_ELEMS + 1),
    localparam int unsigned CNTW = $clog2(IN_ELEMS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic [OFFW-1:0]                  wr_offset,
    input  logic [CNTW-1:0]                  wr_count,
    input  logic [IN_ELEMS*ELEM_WIDTH-1:0]   wr_data,
    output logic [BEAT_ELEMS*ELEM_WIDTH-1:0] stage_data
);

    logic [BEAT_ELEMS*ELEM_WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(BEAT_ELEMS); i++) begin
                for (int j = 0; j < int'(IN_ELEMS); j++) begin
                    if ((j < int'(wr_count)) && (int'(wr_offset) + j == i)) begin
                        stage_d[i*ELEM_WIDTH +: ELEM_WIDTH] = wr_data[j*ELEM_WIDTH +: ELEM_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_data = stage_q;

endmodule

// File: rtl/vivo_frame_packer.sv
// Packs variable-size FIFO pops into fixed-width beats, framed by cfg_frame_len.
// Optional statistics counters enabled by VIVO_FRAME_PACKER_STATS_EN.
module vivo_frame_packer
    import vivo_pkg::*;
#(
    parameter int unsigned ELEM_WIDTH      = VIVO_ELEM_WIDTH,
    parameter int unsigned FIFO_ELEMS_MAX  = VIVO_FIFO_ELEMS_MAX,
    parameter int unsigned BEAT_ELEMS      = VIVO_BEAT_ELEMS,
    parameter int unsigned MAX_FRAME_ELEMS = VIVO_MAX_FRAME_ELEMS,
    localparam int unsigned LENW = $clog2(MAX_FRAME_ELEMS + 1),
    localparam int unsigned FW   = $clog2(BEAT_ELEMS + 1),
    localparam int unsigned RW   = $clog2(FIFO_ELEMS_MAX + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [LENW-1:0]                      cfg_frame_len,
    input  logic                                 fifo_valid,
    output logic                                 fifo_ready,
    input  logic [FIFO_ELEMS_MAX*ELEM_WIDTH-1:0] fifo_data,
    input  logic [RW-1:0]                        fifo_num_elems,
    output logic [RW-1:0]                        fifo_req_elems,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [BEAT_ELEMS*ELEM_WIDTH-1:0]     m_data,
    output logic [FW-1:0]                        m_num_elems,
    output logic                                 m_last,
    output logic                                 err,
    output logic [31:0]                          stat_frames,
    output logic [31:0]                          stat_stall
);

    if (BEAT_ELEMS < FIFO_ELEMS_MAX) begin : g_param_check
        $error("BEAT_ELEMS must be >= FIFO_ELEMS_MAX");
    end

    packer_state_e state_q, state_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [RW-1:0]   req_q, req_d;
    logic            m_valid_q, m_valid_d;
    logic [FW-1:0]   m_num_q, m_num_d;
    logic            m_last_q, m_last_d;
    logic            err_q, err_d;
    logic            pop, accept, stage_clr;
    logic [BEAT_ELEMS*ELEM_WIDTH-1:0] stage_data;

    assign fifo_ready = (state_q == FILL) && (req_q != '0);
    assign pop        = fifo_valid && fifo_ready;
    assign accept     = m_valid_q && m_ready;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        rem_d     = rem_q;
        m_valid_d = m_valid_q;
        m_num_d   = m_num_q;
        m_last_d  = m_last_q;
        err_d     = err_q;
        stage_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_frame_len != '0) begin
                    rem_d   = (cfg_frame_len > LENW'(MAX_FRAME_ELEMS)) ?
                              LENW'(MAX_FRAME_ELEMS) : cfg_frame_len;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (pop) begin
                    fill_d = fill_q + FW'(req_q);
                    rem_d  = rem_q - LENW'(req_q);
                    // Mismatched pop size is flagged but data is taken per req_q.
                    if (fifo_num_elems != req_q) begin
                        err_d = 1'b1;
                    end
                    if ((fill_d == FW'(BEAT_ELEMS)) || (rem_d == '0)) begin
                        state_d   = EMIT;
                        m_valid_d = 1'b1;
                        m_num_d   = fill_d;
                        m_last_d  = (rem_d == '0);
                    end
                end
            end
            EMIT: begin
                if (accept) begin
                    fill_d    = '0;
                    stage_clr = 1'b1;
                    m_valid_d = 1'b0;
                    m_num_d   = '0;
                    m_last_d  = 1'b0;
                    state_d   = m_last_q ? IDLE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only recomputed while staying in FILL, so it holds steady while a pop is pending.
        if ((state_q == FILL) && (state_d == FILL)) begin
            req_d = RW'(vivo_min3(FIFO_ELEMS_MAX, 32'(rem_d), BEAT_ELEMS - 32'(fill_d)));
        end else begin
            req_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fill_q    <= '0;
            rem_q     <= '0;
            req_q     <= '0;
            m_valid_q <= 1'b0;
            m_num_q   <= '0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            rem_q     <= rem_d;
            req_q     <= req_d;
            m_valid_q <= m_valid_d;
            m_num_q   <= m_num_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
        end
    end

    vivo_beat_stager #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .BEAT_ELEMS (BEAT_ELEMS),
        .IN_ELEMS   (FIFO_ELEMS_MAX)
    ) u_stager (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (stage_clr),
        .wr_en      (pop),
        .wr_offset  (fill_q),
        .wr_count   (req_q),
        .wr_data    (fifo_data),
        .stage_data (stage_data)
    );

    assign fifo_req_elems = req_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_valid_q ? stage_data : '0;
    assign m_num_elems    = m_num_q;
    assign m_last         = m_last_q;
    assign err            = err_q;

`ifdef VIVO_FRAME_PACKER_STATS_EN
    logic [31:0] stat_frames_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accept && m_last_q && (stat_frames_q != '1)) begin
                stat_frames_q <= stat_frames_q + 32'd1;
            end
            if (m_valid_q && !m_ready && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_frames = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_vivo_frame_packer.sv
// Randomized self-checking bench for vivo_frame_packer against a queue-based frame model.
module tb_vivo_frame_packer;

    localparam int EW   = 8;
    localparam int FE   = 4;
    localparam int BE   = 8;
    localparam int MAXF = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  cfg_frame_len;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] fifo_data;
    logic [2:0]  fifo_num_elems;
    logic [2:0]  fifo_req_elems;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [3:0]  m_num_elems;
    logic        m_last;
    logic        err;
    logic [31:0] stat_frames;
    logic [31:0] stat_stall;

    always #5 clk = ~clk;

    vivo_frame_packer #(
        .ELEM_WIDTH      (EW),
        .FIFO_ELEMS_MAX  (FE),
        .BEAT_ELEMS      (BE),
        .MAX_FRAME_ELEMS (MAXF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_frame_len  (cfg_frame_len),
        .fifo_valid     (fifo_valid),
        .fifo_ready     (fifo_ready),
        .fifo_data      (fifo_data),
        .fifo_num_elems (fifo_num_elems),
        .fifo_req_elems (fifo_req_elems),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_num_elems    (m_num_elems),
        .m_last         (m_last),
        .err            (err),
        .stat_frames    (stat_frames),
        .stat_stall     (stat_stall)
    );

    typedef struct {
        int num;
        bit last;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        int          num;
        bit          last;
    } got_t;

    int tests = 0;
    int fails = 0;

    byte unsigned fifo_q[$];      // elements still held by the modelled FIFO
    byte unsigned ref_stream[$];  // elements in the order they must appear in beats
    beat_t        exp_beats[$];
    int           exp_reqs[$];
    got_t         got[$];

    int ready_mode  = 0;
    int stall_left  = 0;
    bit num_fault   = 0;
    bit fifo_throttle = 0;
    bit err_exp     = 0;
    int frames_model = 0;
    int stall_model  = 0;
    int pops_seen    = 0;

    // bus-process scratch
    int          req, pop_n;
    logic [2:0]  pop_num;
    bit          do_pop, do_acc, prev_stalled;
    logic [63:0] prev_data, cap_data, ed;
    int          cap_num;
    bit          cap_last;
    beat_t       eb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not observed / unexpected", name);
    endtask

    task automatic push_seq(input int start, input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q.push_back(8'(start + k));
            ref_stream.push_back(8'(start + k));
        end
    endtask

    task automatic push_rand(input int n);
        byte unsigned v;
        for (int k = 0; k < n; k++) begin
            v = 8'($urandom);
            fifo_q.push_back(v);
            ref_stream.push_back(v);
        end
    endtask

    // Frame model: beats of up to BE elements, each filled by pops of up to FE elements.
    task automatic add_frame(input int len);
        int remaining, b, r, q;
        beat_t bt;
        remaining = (len > MAXF) ? MAXF : len;
        while (remaining > 0) begin
            b = (remaining > BE) ? BE : remaining;
            remaining -= b;
            bt.num  = b;
            bt.last = (remaining == 0);
            exp_beats.push_back(bt);
            r = b;
            while (r > 0) begin
                q = (r > FE) ? FE : r;
                exp_reqs.push_back(q);
                r -= q;
            end
        end
    endtask

    task automatic start_frame(input int len);
        @(negedge clk);
        cfg_frame_len = 9'(len);
        add_frame(len);
        @(negedge clk);
        cfg_frame_len = '0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 6000; i++) begin
            if (exp_beats.size() == 0) break;
            @(negedge clk);
        end
        if (exp_beats.size() != 0) fail_now({name, "_timeout"});
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pop(input int p0, input string name);
        for (int i = 0; i < 200; i++) begin
            if (pops_seen > p0) break;
            @(negedge clk);
        end
        if (pops_seen <= p0) fail_now({name, "_pop_timeout"});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_num"}, m_num_elems, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_fifo_ready"}, fifo_ready, 0);
        check({tag, "_req"}, fifo_req_elems, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_stat_frames"}, stat_frames, 0);
        check({tag, "_stat_stall"}, stat_stall, 0);
    endtask

    // FIFO + sink driver and per-cycle compare process.
    always begin
        @(negedge clk);
        req            = int'(fifo_req_elems);
        fifo_valid     = 1'b0;
        fifo_data      = '0;
        fifo_num_elems = '0;
        if (rst_n && req != 0 && fifo_q.size() >= req &&
            (!fifo_throttle || $urandom_range(0, 3) != 0)) begin
            fifo_valid = 1'b1;
            for (int k = 0; k < req; k++) fifo_data[k*EW +: EW] = fifo_q[k];
            fifo_num_elems = num_fault ? 3'(req - 1) : 3'(req);
        end
        if (m_valid && stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
        end else begin
            m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        #1;
        check("err_track", err, err_exp);
        if (m_valid) begin
            check("no_req_in_emit", {fifo_ready, fifo_req_elems}, 0);
            if (prev_stalled) check("stall_hold", m_data, prev_data);
        end
        if (m_valid && !m_ready) stall_model++;
        prev_stalled = m_valid && !m_ready;
        prev_data    = m_data;
        do_pop   = fifo_valid && fifo_ready;
        pop_n    = req;
        pop_num  = fifo_num_elems;
        do_acc   = m_valid && m_ready;
        cap_data = m_data;
        cap_num  = int'(m_num_elems);
        cap_last = m_last;
        @(posedge clk);
        if (rst_n) begin
            if (do_pop) begin
                pops_seen++;
                if (exp_reqs.size() == 0) fail_now("unexpected_pop");
                else check("req_size", 64'(pop_n), 64'(exp_reqs.pop_front()));
                if (pop_num != 3'(pop_n)) err_exp = 1'b1;
                repeat (pop_n) void'(fifo_q.pop_front());
            end
            if (do_acc) begin
                got.push_back('{data: cap_data, num: cap_num, last: cap_last});
                if (exp_beats.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    eb = exp_beats.pop_front();
                    ed = '0;
                    for (int k = 0; k < eb.num; k++) begin
                        if (ref_stream.size() != 0) ed[k*EW +: EW] = ref_stream.pop_front();
                    end
                    check("beat_num", 64'(cap_num), 64'(eb.num));
                    check("beat_last", cap_last, eb.last);
                    check("beat_data", cap_data, ed);
                    if (eb.last) frames_model++;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, p0, len, eff, st0;
        cfg_frame_len  = '0;
        fifo_valid     = 1'b0;
        fifo_data      = '0;
        fifo_num_elems = '0;
        m_ready        = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // 1: single full beat, request latency
        b = got.size();
        push_seq(0, 8);
        start_frame(8);
        check("lat_req_first", fifo_req_elems, 0);
        @(negedge clk);
        check("lat_req_second", fifo_req_elems, 4);
        wait_done("t1");
        if (got.size() > b) begin
            check("t1_data", got[b].data, 64'h0706050403020100);
            check("t1_num", 64'(got[b].num), 8);
            check("t1_last", got[b].last, 1);
        end else fail_now("t1_no_beat");

        // 2: frame of 11 -> full beat then partial beat
        b  = got.size();
        p0 = pops_seen;
        push_seq(0, 11);
        start_frame(11);
        wait_done("t2");
        check("t2_pops", 64'(pops_seen - p0), 3);
        if (got.size() > b + 1) begin
            check("t2_b0_data", got[b].data, 64'h0706050403020100);
            check("t2_b0_last", got[b].last, 0);
            check("t2_b1_data", got[b+1].data, 64'h00000000000A0908);
            check("t2_b1_num", 64'(got[b+1].num), 3);
            check("t2_b1_last", got[b+1].last, 1);
        end else fail_now("t2_beats");

        // 3: 10-cycle output stall
        st0 = stall_model;
        stall_left = 10;
        push_seq(0, 8);
        start_frame(8);
        wait_done("t3");
        check("t3_stall_cycles", 64'(stall_model - st0), 10);

        // 4: FIFO short of the request -> req held, no pop
        b = got.size();
        push_seq(0, 2);
        start_frame(6);
        p0 = pops_seen;
        repeat (6) begin
            @(negedge clk);
            #2;
            check("t4_req_hold", fifo_req_elems, 4);
            check("t4_ready", fifo_ready, 1);
        end
        check("t4_no_pop", 64'(pops_seen - p0), 0);
        push_seq(2, 2);
        wait_pop(p0, "t4");
        @(negedge clk);
        #2;
        check("t4_req_after", fifo_req_elems, 2);
        push_seq(4, 2);
        wait_done("t4");
        if (got.size() > b) check("t4_data", got[b].data, 64'h0000050403020100);
        else fail_now("t4_no_beat");

        // 5: reset after first pop
        push_seq(0, 8);
        start_frame(8);
        wait_pop(pops_seen, "t5");
        @(posedge clk);
        #2 rst_n = 1'b0;
        fifo_q.delete();
        ref_stream.delete();
        exp_reqs.delete();
        exp_beats.delete();
        err_exp = 1'b0;
        frames_model = 0;
        stall_model  = 0;
        #1;
        check_zero("t5_mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        b = got.size();
        push_seq(0, 4);
        start_frame(4);
        wait_done("t5");
        check("t5_err", err, 0);
        if (got.size() > b) begin
            check("t5_data", got[b].data, 64'h0000000003020100);
            check("t5_num", 64'(got[b].num), 4);
        end else fail_now("t5_no_beat");

        // 6: wrong pop count sets sticky err; zero length stays idle
        num_fault = 1'b1;
        push_seq(0, 4);
        p0 = pops_seen;
        start_frame(4);
        wait_pop(p0, "t6");
        num_fault = 1'b0;
        wait_done("t6");
        check("t6_err", err, 1);
        push_seq(0, 5);
        start_frame(5);
        wait_done("t6b");
        check("t6_err_sticky", err, 1);
        cfg_frame_len = '0;
        repeat (12) begin
            @(negedge clk);
            #2;
            check("len0_req", fifo_req_elems, 0);
            check("len0_valid", m_valid, 0);
        end

        // random traffic
        ready_mode    = 1;
        fifo_throttle = 1'b1;
        for (int f = 0; f < 14; f++) begin
            len = $urandom_range(1, 300);
            eff = (len > MAXF) ? MAXF : len;
            push_rand(eff / 2);
            start_frame(len);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            push_rand(eff - eff / 2);
            wait_done("rand");
        end
        ready_mode = 0;
        repeat (3) @(negedge clk);

`ifdef VIVO_FRAME_PACKER_STATS_EN
        check("stat_frames", stat_frames, 64'(frames_model));
        check("stat_stall", stat_stall, 64'(stall_model));
`else
        check("stat_frames_tied", stat_frames, 0);
        check("stat_stall_tied", stat_stall, 0);
`endif
        check("leftover_reqs", 64'(exp_reqs.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
